// File: rtl/usb_rx_sequencer.sv
// USB receive sequencer: bit-strobe timing, SYNC detection, bit unstuffing, byte assembly and EOP checking.
// Optional macro USB_RX_STUFF_ERR_EN: a stuff bit sampled as 1 is treated as a packet error.
module usb_rx_sequencer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dp_in,
  input  logic       dm_in,
  input  logic       d_orig,
  input  logic       d_edge,
  output logic       en,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rx_active,
  output logic       eop,
  output logic       rx_error
);

  localparam int PW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    EOP   = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t         r_state, w_state;
  logic [PW-1:0]  r_phase, w_phase;
  logic [2:0]     r_zeros, w_zeros;
  logic [2:0]     r_ones, w_ones;
  logic [2:0]     r_bitcnt, w_bitcnt;
  logic [7:0]     r_shift, w_shift;
  logic [7:0]     r_rx_byte, w_rx_byte;
  logic           r_byte_valid, w_byte_valid;
  logic           r_eop, w_eop;
  logic           r_rx_error, w_rx_error;
  logic           r_se0_seen, w_se0_seen;
  logic           w_en, w_se0, w_j;

  assign w_en  = (r_state != IDLE) && (r_phase == PW'(CLKS_PER_BIT / 2));
  assign w_se0 = !dp_in && !dm_in;
  assign w_j   = dp_in && !dm_in;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      r_zeros      <= '0;
      r_ones       <= '0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_rx_byte    <= '0;
      r_byte_valid <= 1'b0;
      r_eop        <= 1'b0;
      r_rx_error   <= 1'b0;
      r_se0_seen   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_phase      <= w_phase;
      r_zeros      <= w_zeros;
      r_ones       <= w_ones;
      r_bitcnt     <= w_bitcnt;
      r_shift      <= w_shift;
      r_rx_byte    <= w_rx_byte;
      r_byte_valid <= w_byte_valid;
      r_eop        <= w_eop;
      r_rx_error   <= w_rx_error;
      r_se0_seen   <= w_se0_seen;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_zeros      = r_zeros;
    w_ones       = r_ones;
    w_bitcnt     = r_bitcnt;
    w_shift      = r_shift;
    w_rx_byte    = r_rx_byte;
    w_byte_valid = 1'b0;
    w_eop        = 1'b0;
    w_rx_error   = r_rx_error;
    w_se0_seen   = r_se0_seen;

    // Phase holds at 0 while idle; any line transition re-centres the strobe.
    if (r_state == IDLE)
      w_phase = d_edge ? PW'(1) : '0;
    else if (d_edge)
      w_phase = PW'(1);
    else if (r_phase == PW'(CLKS_PER_BIT - 1))
      w_phase = '0;
    else
      w_phase = r_phase + PW'(1);

    case (r_state)
      IDLE: begin
        if (d_edge) begin
          w_state    = SYNC;
          w_rx_error = 1'b0;
          w_zeros    = '0;
        end
      end
      SYNC: begin
        if (w_en) begin
          if (w_se0) begin
            w_state = IDLE;
          end else if (d_orig) begin
            w_state  = (r_zeros >= 3'd5) ? DATA : IDLE;
            w_ones   = '0;
            w_bitcnt = '0;
          end else if (r_zeros != 3'd5) begin
            w_zeros = r_zeros + 3'd1;
          end
        end
      end
      DATA: begin
        if (w_en) begin
          if (w_se0) begin
            w_state    = EOP;
            w_se0_seen = 1'b0;
            if (r_bitcnt != 3'd0)
              w_rx_error = 1'b1;
          end else if (r_ones == 3'd6) begin
            w_ones = '0;
`ifdef USB_RX_STUFF_ERR_EN
            if (d_orig) begin
              w_rx_error = 1'b1;
              w_state    = ERROR;
              w_se0_seen = 1'b0;
            end
`endif
          end else begin
            w_shift  = {d_orig, r_shift[7:1]};
            w_ones   = d_orig ? r_ones + 3'd1 : 3'd0;
            w_bitcnt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_rx_byte    = {d_orig, r_shift[7:1]};
              w_byte_valid = 1'b1;
            end
          end
        end
      end
      EOP: begin
        if (w_en) begin
          if (w_se0 && !r_se0_seen) begin
            w_se0_seen = 1'b1;
          end else if (w_j && r_se0_seen) begin
            w_eop   = 1'b1;
            w_state = IDLE;
          end else begin
            w_rx_error = 1'b1;
            w_state    = ERROR;
            w_se0_seen = 1'b0;
          end
        end
      end
      ERROR: begin
        if (w_en) begin
          w_se0_seen = w_se0;
          if (w_j && r_se0_seen)
            w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign en         = w_en;
  assign rx_byte    = r_rx_byte;
  assign byte_valid = r_byte_valid;
  assign eop        = r_eop;
  assign rx_error   = r_rx_error;
  assign rx_active  = (r_state == DATA) || (r_state == EOP);

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Directed bench for usb_rx_sequencer: NRZI line driver with a small decoder model and pulse monitors.
module tb_usb_rx_sequencer;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       dp_in = 1'b1;
  logic       dm_in = 1'b0;
  logic       d_orig, d_edge;
  logic       en, byte_valid, rx_active, eop, rx_error;
  logic [7:0] rx_byte;

  logic tb_prev_dp = 1'b1;
  logic tb_prev_dm = 1'b0;
  logic tb_last_dp = 1'b1;
  logic cur_dp = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int bv_cnt = 0, eop_cnt = 0, en_cnt = 0, both_cnt = 0;
  logic [7:0] byte_log[$];

  usb_rx_sequencer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .n_rst(n_rst), .dp_in(dp_in), .dm_in(dm_in),
    .d_orig(d_orig), .d_edge(d_edge), .en(en), .rx_byte(rx_byte),
    .byte_valid(byte_valid), .rx_active(rx_active), .eop(eop), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  // Decoder model: edge = line changed since last clock; bit = line equal to the last strobed level.
  assign d_edge = (dp_in != tb_prev_dp) || (dm_in != tb_prev_dm);
  assign d_orig = (dp_in == tb_last_dp);

  always @(posedge clk) begin
    tb_prev_dp <= dp_in;
    tb_prev_dm <= dm_in;
    if (!n_rst)  tb_last_dp <= 1'b1;
    else if (en) tb_last_dp <= dp_in;
  end

  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt++;
      byte_log.push_back(rx_byte);
    end
    if (eop) eop_cnt++;
    if (en) en_cnt++;
    if (byte_valid && eop) both_cnt++;
  end

  task automatic drive_line(input logic dp, input logic dm);
    dp_in = dp;
    dm_in = dm;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic nrzi(input logic b);
    if (!b) cur_dp = !cur_dp;
    drive_line(cur_dp, !cur_dp);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) nrzi(1'b0);
    nrzi(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) nrzi(b[i]);
  endtask

  task automatic send_eop();
    drive_line(1'b0, 1'b0);
    drive_line(1'b0, 1'b0);
    cur_dp = 1'b1;
    drive_line(1'b1, 1'b0);
    drive_line(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if ({en, byte_valid, eop, rx_active, rx_error} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b expected 00000", {en, byte_valid, eop, rx_active, rx_error}); end
    n_cmp++; if (rx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_rx_byte: got %h expected 00", rx_byte); end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int bv0, eop0;
    bv0 = bv_cnt; eop0 = eop_cnt;
    send_sync();
    n_cmp++; if (rx_active !== 1'b1) begin n_bad++; $display("FAIL basic_active: got %b expected 1", rx_active); end
    send_byte(8'hA5);
    send_eop();
    n_cmp++; if (bv_cnt - bv0 !== 1) begin n_bad++; $display("FAIL basic_bv_count: got %0d expected 1", bv_cnt - bv0); end
    n_cmp++; if (byte_log[byte_log.size()-1] !== 8'hA5) begin n_bad++; $display("FAIL basic_byte: got %h expected a5", byte_log[byte_log.size()-1]); end
    n_cmp++; if (eop_cnt - eop0 !== 1) begin n_bad++; $display("FAIL basic_eop: got %0d expected 1", eop_cnt - eop0); end
    n_cmp++; if ({rx_error, rx_active} !== 2'b00) begin n_bad++; $display("FAIL basic_err_active: got %b expected 00", {rx_error, rx_active}); end
    $display("test_basic: byte A5 packet");
  endtask

  task automatic test_stuff();
    int bv0, eop0;
    bv0 = bv_cnt; eop0 = eop_cnt;
    send_sync();
    for (int i = 0; i < 6; i++) nrzi(1'b1);
    nrzi(1'b0);
    nrzi(1'b1); nrzi(1'b1);
    send_byte(8'h01);
    send_eop();
    n_cmp++; if (bv_cnt - bv0 !== 2) begin n_bad++; $display("FAIL stuff_bv_count: got %0d expected 2", bv_cnt - bv0); end
    n_cmp++; if (byte_log[byte_log.size()-2] !== 8'hFF) begin n_bad++; $display("FAIL stuff_byte0: got %h expected ff", byte_log[byte_log.size()-2]); end
    n_cmp++; if (byte_log[byte_log.size()-1] !== 8'h01) begin n_bad++; $display("FAIL stuff_byte1: got %h expected 01", byte_log[byte_log.size()-1]); end
    n_cmp++; if ({eop_cnt - eop0, 31'(rx_error)} !== {32'd1, 31'd0}) begin n_bad++; $display("FAIL stuff_eop_err: got eop=%0d err=%b expected eop=1 err=0", eop_cnt - eop0, rx_error); end
    $display("test_stuff: FF + stuffed 0 + 01");
  endtask

  task automatic test_stuff_one();
    int bv0, eop0;
    bv0 = bv_cnt; eop0 = eop_cnt;
    send_sync();
    for (int i = 0; i < 7; i++) nrzi(1'b1);
`ifdef USB_RX_STUFF_ERR_EN
    n_cmp++; if ({rx_error, rx_active} !== 2'b10) begin n_bad++; $display("FAIL stuff1_error: got err/active=%b expected 10", {rx_error, rx_active}); end
`else
    n_cmp++; if ({rx_error, rx_active} !== 2'b01) begin n_bad++; $display("FAIL stuff1_noerr: got err/active=%b expected 01", {rx_error, rx_active}); end
`endif
    nrzi(1'b1); nrzi(1'b1);
    send_eop();
`ifdef USB_RX_STUFF_ERR_EN
    n_cmp++; if (bv_cnt - bv0 !== 0 || eop_cnt - eop0 !== 0) begin n_bad++; $display("FAIL stuff1_pulses: got bv=%0d eop=%0d expected 0 0", bv_cnt - bv0, eop_cnt - eop0); end
`else
    n_cmp++; if (bv_cnt - bv0 !== 1 || eop_cnt - eop0 !== 1 || rx_error !== 1'b0) begin n_bad++; $display("FAIL stuff1_pulses: got bv=%0d eop=%0d err=%b expected 1 1 0", bv_cnt - bv0, eop_cnt - eop0, rx_error); end
    n_cmp++; if (byte_log[byte_log.size()-1] !== 8'hFF) begin n_bad++; $display("FAIL stuff1_byte: got %h expected ff", byte_log[byte_log.size()-1]); end
`endif
    $display("test_stuff_one: seven ones");
  endtask

  task automatic test_partial();
    int bv0, eop0;
    bv0 = bv_cnt; eop0 = eop_cnt;
    send_sync();
    nrzi(1'b1); nrzi(1'b0); nrzi(1'b1);
    drive_line(1'b0, 1'b0);
    n_cmp++; if (rx_error !== 1'b1) begin n_bad++; $display("FAIL partial_err_at_se0: got %b expected 1", rx_error); end
    drive_line(1'b0, 1'b0);
    cur_dp = 1'b1;
    drive_line(1'b1, 1'b0);
    drive_line(1'b1, 1'b0);
    n_cmp++; if (eop_cnt - eop0 !== 1 || bv_cnt - bv0 !== 0) begin n_bad++; $display("FAIL partial_pulses: got eop=%0d bv=%0d expected 1 0", eop_cnt - eop0, bv_cnt - bv0); end
    n_cmp++; if ({rx_error, rx_active} !== 2'b10) begin n_bad++; $display("FAIL partial_final: got err/active=%b expected 10", {rx_error, rx_active}); end
    $display("test_partial: SE0 after 3 bits");
  endtask

  task automatic test_back_to_back();
    int bv0;
    bv0 = bv_cnt;
    nrzi(1'b0);
    n_cmp++; if (rx_error !== 1'b0) begin n_bad++; $display("FAIL b2b_err_cleared: got %b expected 0", rx_error); end
    for (int i = 0; i < 6; i++) nrzi(1'b0);
    nrzi(1'b1);
    send_byte(8'h3C);
    send_eop();
    n_cmp++; if (bv_cnt - bv0 !== 1 || byte_log[byte_log.size()-1] !== 8'h3C) begin n_bad++; $display("FAIL b2b_byte: got bv=%0d byte=%h expected 1 3c", bv_cnt - bv0, byte_log[byte_log.size()-1]); end
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL bv_eop_overlap: got %0d expected 0", both_cnt); end
    $display("test_back_to_back: byte 3C after errored packet");
  endtask

  task automatic test_short_sync();
    int bv0, en0;
    bv0 = bv_cnt;
    nrzi(1'b0); nrzi(1'b0); nrzi(1'b1);
    en0 = en_cnt;
    drive_line(1'b1, 1'b0);
    drive_line(1'b1, 1'b0);
    drive_line(1'b1, 1'b0);
    n_cmp++; if (en_cnt - en0 !== 0) begin n_bad++; $display("FAIL short_idle_en: got %0d strobes expected 0", en_cnt - en0); end
    n_cmp++; if ({rx_active, rx_error} !== 2'b00 || bv_cnt - bv0 !== 0) begin n_bad++; $display("FAIL short_outputs: got active/err=%b bv=%0d expected 00 0", {rx_active, rx_error}, bv_cnt - bv0); end
    $display("test_short_sync: two zeros then one");
  endtask

  task automatic test_reset_mid();
    int bv0, eop0;
    send_sync();
    nrzi(1'b1); nrzi(1'b0); nrzi(1'b1); nrzi(1'b0);
    n_rst = 1'b0;
    #1;
    n_cmp++; if ({en, byte_valid, eop, rx_active, rx_error, rx_byte} !== 13'b0) begin n_bad++; $display("FAIL reset_mid_outputs: got %b expected 0", {en, byte_valid, eop, rx_active, rx_error, rx_byte}); end
    cur_dp = 1'b1;
    dp_in = 1'b1; dm_in = 1'b0;
    repeat (3) @(negedge clk);
    bv0 = bv_cnt; eop0 = eop_cnt;
    n_rst = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    n_cmp++; if (bv_cnt - bv0 !== 0 || eop_cnt - eop0 !== 0) begin n_bad++; $display("FAIL reset_mid_pulses: got bv=%0d eop=%0d expected 0 0", bv_cnt - bv0, eop_cnt - eop0); end
    $display("test_reset_mid: reset after 4 data bits");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuff();
    test_stuff_one();
    test_partial();
    test_back_to_back();
    test_short_sync();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_rx_sequencer.md
USB_RX_SEQUENCER -- requirements
Module: usb_rx_sequencer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, system clocks per USB bit period (even, >=4).
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port dp_in  input  1  synchronized D+ line level.
REQ-005 SHALL have port dm_in  input  1  synchronized D- line level.
REQ-006 SHALL have port d_orig  input  1  combinational decoded NRZI bit from the decoder (1 = no transition).
REQ-007 SHALL have port d_edge  input  1  combinational line-transition flag from the decoder.
REQ-008 SHALL have port en  output  1  one-cycle bit-sample strobe driven to the NRZI decoder.
REQ-009 SHALL have port rx_byte  output  8  last completed received byte.
REQ-010 SHALL have port byte_valid  output  1  one-cycle pulse when rx_byte is updated.
REQ-011 SHALL have port rx_active  output  1  high from SYNC completion until packet end.
REQ-012 SHALL have port eop  output  1  one-cycle pulse on a valid end-of-packet.
REQ-013 SHALL have port rx_error  output  1  sticky packet error, cleared when the next packet starts.

Function
REQ-014 SHALL have a phase counter 0..CLKS_PER_BIT-1, wrapping; d_edge outside IDLE loads it with 1 (resync).
REQ-015 SHALL assert en for exactly one cycle when the phase counter equals CLKS_PER_BIT/2, in all states except IDLE.
REQ-016 SHALL sample d_orig, dp_in and dm_in only in cycles where en is high.
REQ-017 SHALL implement states IDLE, SYNC, DATA, EOP, ERROR.
REQ-018 IDLE: on d_edge, phase counter loads 1, clear rx_error, go to SYNC.
REQ-019 SYNC: count consecutive sampled 0s; a sampled 1 after >=5 zeros goes to DATA with rx_active=1; a sampled 1 after <5 zeros goes to IDLE.
REQ-020 DATA: bits LSB first; non-stuff bits shift into the byte register; after the 8th, rx_byte updates and byte_valid pulses the following cycle.
REQ-021 SHALL count consecutive sampled 1s in DATA (saturating at 6); the bit sampled after six 1s is a stuff bit and is never shifted in.
REQ-022 A sampled 0 also resets the ones counter; the stuff bit resets it to 0.
REQ-023 SE0 (dp_in=0, dm_in=0) at a strobe in DATA SHALL go to EOP without shifting a bit; SE0 at a strobe in SYNC SHALL go to IDLE.
REQ-024 EOP: second consecutive SE0 strobe then a J strobe (dp_in=1, dm_in=0) SHALL pulse eop, drop rx_active, go to IDLE.
REQ-025 EOP: any other strobe pattern SHALL set rx_error and go to ERROR.
REQ-026 Entering EOP with a partial byte (1..7 bits pending) SHALL set rx_error; eop still pulses if the EOP is valid.
REQ-027 ERROR: rx_active low; go to IDLE after a J strobe following an SE0 strobe; no byte_valid while in ERROR.
REQ-028 byte_valid and eop SHALL never be high in the same cycle.

Reset
REQ-029 n_rst low SHALL force IDLE, phase counter 0, ones/zeros/bit counters 0, rx_byte=8'h00, en=0, byte_valid=0, rx_active=0, eop=0, rx_error=0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet with no byte_valid or eop pulse afterward.

Configuration
REQ-031 Macro USB_RX_STUFF_ERR_EN defined: a stuff bit sampled as 1 SHALL set rx_error and go to ERROR.
REQ-032 Macro undefined: the stuff bit SHALL be discarded whatever its value, with no error.

Verification
REQ-033 SYNC KJKJKJKK, then data byte 8'hA5 NRZI-encoded, then SE0,SE0,J -> byte_valid once with rx_byte=8'hA5, eop one pulse, rx_error=0.
REQ-034 Byte 8'hFF followed by a stuffed 0, then 8'h01 -> two byte_valid pulses with 8'hFF and 8'h01; stuff bit not shifted in.
REQ-035 Seven consecutive 1s in DATA -> with USB_RX_STUFF_ERR_EN: rx_error=1, ERROR state, no further byte_valid; without: no error.
REQ-036 SE0 after 3 data bits -> rx_error=1, eop pulses after SE0,SE0,J, rx_active=0.
REQ-037 Line edge, then only 2 sampled 0s, then a 1 -> returns to IDLE, rx_active stays 0.
REQ-038 n_rst low during DATA after 4 bits -> all outputs 0 in the same cycle; no byte_valid or eop follows.
